// File: rtl/nexus_pkg.sv
// Shared definitions for the nexus EX/MEM stage: ALU op codes, flag bit
// positions, buffer state encoding and the per-op flag update mask.
package nexus_pkg;

    localparam int DATA_W = 16;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_INC  = 4'b0101;
    localparam logic [3:0] OP_SHL  = 4'b0110;
    localparam logic [3:0] OP_NOT  = 4'b0111;
    localparam logic [3:0] OP_CMP  = 4'b1000;
    localparam logic [3:0] OP_SHR  = 4'b1001;
    localparam logic [3:0] OP_DEC  = 4'b1010;
    localparam logic [3:0] OP_MOV  = 4'b1011;
    localparam logic [3:0] OP_ROL  = 4'b1100;
    localparam logic [3:0] OP_NOP  = 4'b1101;
    localparam logic [3:0] OP_LDI  = 4'b1110;
    localparam logic [3:0] OP_PASS = 4'b1111;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } buf_state_t;

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic              wb_en;
        logic              mem_rd;
        logic              mem_wr;
        logic [DATA_W-1:0] store_data;
    } ex_payload_t;

    // Which of {N,Z,C,V} an op is allowed to overwrite; cleared bits keep their value.
    function automatic logic [3:0] flag_mask(input logic [3:0] op);
        logic [3:0] m;
        case (op)
            OP_ADD, OP_SUB, OP_CMP:                          m = 4'b1111;
            OP_SHR, OP_ROL, OP_SHL:                          m = 4'b1110;
            OP_AND, OP_OR, OP_XOR, OP_INC, OP_NOT,
            OP_DEC, OP_MOV:                                  m = 4'b1100;
            default:                                         m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/nexus_flag_reg.sv
// Committed NZCV flag register; merges new ALU flags under the per-op mask.
module nexus_flag_reg
    import nexus_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       commit,
    input  logic [3:0] alu_op,
    input  logic       n,
    input  logic       z,
    input  logic       c,
    input  logic       v,
    output logic [3:0] flags
);

    logic [3:0] mask;
    logic [3:0] raw;
    logic [3:0] merged;
    logic [3:0] flags_q;

    always_comb begin
        mask   = flag_mask(alu_op);
        raw    = {n, z, c, v};
        merged = (raw & mask) | (flags_q & ~mask);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q <= 4'b0000;
        end else if (commit) begin
            flags_q <= merged;
        end
    end

    assign flags = flags_q;

endmodule

// File: rtl/nexus_ex_mem_stage.sv
// EX/MEM boundary: two-entry in-order skid buffer plus committed flag register.
// Define NEXUS_EXMEM_FWD_EN to expose the head entry as a forwarding source.
module nexus_ex_mem_stage
    import nexus_pkg::*;
#(
    parameter int RD_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_alu_op,
    input  logic [DATA_W-1:0] in_result,
    input  logic              in_n,
    input  logic              in_z,
    input  logic              in_c,
    input  logic              in_v,
    input  logic              in_set_flags,
    input  logic [RD_W-1:0]   in_rd,
    input  logic              in_wb_en,
    input  logic              in_mem_rd,
    input  logic              in_mem_wr,
    input  logic [DATA_W-1:0] in_store_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [RD_W-1:0]   out_rd,
    output logic              out_wb_en,
    output logic              out_mem_rd,
    output logic              out_mem_wr,
    output logic [DATA_W-1:0] out_store_data,
`ifdef NEXUS_EXMEM_FWD_EN
    output logic              fwd_valid,
    output logic [RD_W-1:0]   fwd_rd,
    output logic [DATA_W-1:0] fwd_result,
`endif
    output logic [3:0]        flags_nzcv,
    output logic              carry_out
);

    buf_state_t        state_q;
    buf_state_t        state_d;
    logic              in_ready_q;
    logic              accept;
    logic              emit;
    logic              load_head;
    logic              load_skid;
    logic              promote_skid;
    logic              flag_commit;

    ex_payload_t       in_pl;
    ex_payload_t       head_pl_p1;
    ex_payload_t       skid_pl_p1;
    logic [RD_W-1:0]   head_rd_p1;
    logic [RD_W-1:0]   skid_rd_p1;

    assign in_pl = '{result:     in_result,
                     wb_en:      in_wb_en,
                     mem_rd:     in_mem_rd,
                     mem_wr:     in_mem_wr,
                     store_data: in_store_data};

    assign accept = in_valid && in_ready_q;
    assign emit   = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != ST_TWO);
        end
    end

    always_comb begin
        state_d      = state_q;
        load_head    = 1'b0;
        load_skid    = 1'b0;
        promote_skid = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d   = ST_ONE;
                    load_head = 1'b1;
                end
            end
            ST_ONE: begin
                case ({accept, emit})
                    2'b10: begin
                        state_d   = ST_TWO;
                        load_skid = 1'b1;
                    end
                    2'b01: state_d = ST_EMPTY;
                    2'b11: begin
                        state_d   = ST_ONE;
                        load_head = 1'b1;
                    end
                    default: state_d = ST_ONE;
                endcase
            end
            ST_TWO: begin
                // in_ready is low here, so only draining is possible
                if (emit) begin
                    state_d      = ST_ONE;
                    promote_skid = 1'b1;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        if (flush) begin
            state_d      = ST_EMPTY;
            load_head    = 1'b0;
            load_skid    = 1'b0;
            promote_skid = 1'b0;
        end
    end

    always_comb begin
        out_valid = (state_q != ST_EMPTY);
        in_ready  = in_ready_q;
    end

    // p1: head and skid payload registers
    always_ff @(posedge clk) begin
        if (rst) begin
            head_pl_p1 <= '0;
            head_rd_p1 <= '0;
            skid_pl_p1 <= '0;
            skid_rd_p1 <= '0;
        end else begin
            if (load_head) begin
                head_pl_p1 <= in_pl;
                head_rd_p1 <= in_rd;
            end else if (promote_skid) begin
                head_pl_p1 <= skid_pl_p1;
                head_rd_p1 <= skid_rd_p1;
            end
            if (load_skid) begin
                skid_pl_p1 <= in_pl;
                skid_rd_p1 <= in_rd;
            end
        end
    end

    assign out_result     = head_pl_p1.result;
    assign out_rd         = head_rd_p1;
    assign out_wb_en      = head_pl_p1.wb_en;
    assign out_mem_rd     = head_pl_p1.mem_rd;
    assign out_mem_wr     = head_pl_p1.mem_wr;
    assign out_store_data = head_pl_p1.store_data;

`ifdef NEXUS_EXMEM_FWD_EN
    // Loads have no value yet at this stage, so they are not forwardable.
    assign fwd_valid  = out_valid && head_pl_p1.wb_en && !head_pl_p1.mem_rd;
    assign fwd_rd     = head_rd_p1;
    assign fwd_result = head_pl_p1.result;
`endif

    // Flags commit in program order at accept; a flushed instruction never commits.
    assign flag_commit = accept && in_set_flags && !flush;

    nexus_flag_reg u_flag_reg (
        .clk    (clk),
        .rst    (rst),
        .commit (flag_commit),
        .alu_op (in_alu_op),
        .n      (in_n),
        .z      (in_z),
        .c      (in_c),
        .v      (in_v),
        .flags  (flags_nzcv)
    );

    assign carry_out = flags_nzcv[FLAG_C];

endmodule

// File: tb/tb_nexus_ex_mem_stage.sv
// Scoreboard bench for nexus_ex_mem_stage: a negedge monitor models buffer
// occupancy and flags, pushing accepted items and comparing the head entry.
module tb_nexus_ex_mem_stage;

    localparam int RD_W = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [3:0]      in_alu_op = '0;
    logic [15:0]     in_result = '0;
    logic            in_n = 1'b0, in_z = 1'b0, in_c = 1'b0, in_v = 1'b0;
    logic            in_set_flags = 1'b0;
    logic [RD_W-1:0] in_rd = '0;
    logic            in_wb_en = 1'b0, in_mem_rd = 1'b0, in_mem_wr = 1'b0;
    logic [15:0]     in_store_data = '0;
    logic            flush = 1'b0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [15:0]     out_result;
    logic [RD_W-1:0] out_rd;
    logic            out_wb_en, out_mem_rd, out_mem_wr;
    logic [15:0]     out_store_data;
`ifdef NEXUS_EXMEM_FWD_EN
    logic            fwd_valid;
    logic [RD_W-1:0] fwd_rd;
    logic [15:0]     fwd_result;
`endif
    logic [3:0]      flags_nzcv;
    logic            carry_out;

    always #5 clk = ~clk;

    nexus_ex_mem_stage #(.RD_W(RD_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_alu_op(in_alu_op), .in_result(in_result),
        .in_n(in_n), .in_z(in_z), .in_c(in_c), .in_v(in_v),
        .in_set_flags(in_set_flags), .in_rd(in_rd), .in_wb_en(in_wb_en),
        .in_mem_rd(in_mem_rd), .in_mem_wr(in_mem_wr), .in_store_data(in_store_data),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_rd(out_rd), .out_wb_en(out_wb_en),
        .out_mem_rd(out_mem_rd), .out_mem_wr(out_mem_wr), .out_store_data(out_store_data),
`ifdef NEXUS_EXMEM_FWD_EN
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_result(fwd_result),
`endif
        .flags_nzcv(flags_nzcv), .carry_out(carry_out)
    );

    typedef struct {
        logic [15:0]     res;
        logic [RD_W-1:0] rd;
        logic            wb;
        logic            mrd;
        logic            mwr;
        logic [15:0]     sd;
    } item_t;

    int    n_checks = 0;
    int    n_errs   = 0;
    item_t q[$];
    logic [3:0] mflags = 4'b0000;
    logic  rdy_ok = 1'b0;
    logic  armed  = 1'b0;
    int    emits  = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] upd(input logic [3:0] f, input logic [3:0] op,
                                       input logic [3:0] raw);
        logic [3:0] m;
        case (op)
            4'b0000, 4'b0001, 4'b1000: m = 4'b1111;
            4'b1001, 4'b1100, 4'b0110: m = 4'b1110;
            4'b1101, 4'b1110, 4'b1111: m = 4'b0000;
            default:                   m = 4'b1100;
        endcase
        return (raw & m) | (f & ~m);
    endfunction

    function automatic item_t rnd_item();
        item_t it;
        it.res = 16'($urandom);
        it.rd  = RD_W'($urandom);
        it.wb  = 1'($urandom);
        it.mrd = 1'($urandom);
        it.mwr = 1'($urandom);
        it.sd  = 16'($urandom);
        return it;
    endfunction

    function automatic item_t mk(input logic [15:0] res, input logic [RD_W-1:0] rd,
                                 input logic wb, input logic mrd);
        item_t it;
        it.res = res; it.rd = rd; it.wb = wb; it.mrd = mrd; it.mwr = 1'b0;
        it.sd  = ~res;
        return it;
    endfunction

    // Monitor: everything sampled here is what the next rising edge will see.
    always @(negedge clk) begin
        item_t cur;
        if (armed) begin
            chk("in_ready", 32'(in_ready), 32'(rdy_ok && (q.size() < 2)));
            chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
            chk("flags_nzcv", 32'(flags_nzcv), 32'(mflags));
            chk("carry_out", 32'(carry_out), 32'(mflags[1]));
            if (out_valid && q.size() != 0) begin
                chk("out_result", 32'(out_result), 32'(q[0].res));
                chk("out_rd", 32'(out_rd), 32'(q[0].rd));
                chk("out_wb_en", 32'(out_wb_en), 32'(q[0].wb));
                chk("out_mem_rd", 32'(out_mem_rd), 32'(q[0].mrd));
                chk("out_mem_wr", 32'(out_mem_wr), 32'(q[0].mwr));
                chk("out_store_data", 32'(out_store_data), 32'(q[0].sd));
`ifdef NEXUS_EXMEM_FWD_EN
                chk("fwd_valid", 32'(fwd_valid), 32'(q[0].wb && !q[0].mrd));
                chk("fwd_rd", 32'(fwd_rd), 32'(q[0].rd));
                chk("fwd_result", 32'(fwd_result), 32'(q[0].res));
`endif
            end
        end
        if (rst) begin
            q.delete();
            mflags = 4'b0000;
            rdy_ok = 1'b0;
            armed  = 1'b1;
        end else begin
            if (flush) begin
                q.delete();
            end else begin
                if (out_valid && out_ready && q.size() != 0) begin
                    void'(q.pop_front());
                    emits++;
                end
                if (in_valid && in_ready) begin
                    cur.res = in_result; cur.rd = in_rd; cur.wb = in_wb_en;
                    cur.mrd = in_mem_rd; cur.mwr = in_mem_wr; cur.sd = in_store_data;
                    q.push_back(cur);
                    if (in_set_flags)
                        mflags = upd(mflags, in_alu_op, {in_n, in_z, in_c, in_v});
                end
            end
            rdy_ok = 1'b1;
        end
    end

    task automatic drive(input item_t it, input logic [3:0] op, input logic [3:0] nzcv,
                         input logic sf);
        in_valid = 1'b1;
        in_alu_op = op;
        {in_n, in_z, in_c, in_v} = nzcv;
        in_set_flags = sf;
        in_result = it.res; in_rd = it.rd; in_wb_en = it.wb;
        in_mem_rd = it.mrd; in_mem_wr = it.mwr; in_store_data = it.sd;
    endtask

    // Returns at #1 after the accepting edge; stalls counts cycles with in_ready low.
    task automatic wait_accept(output int stalls);
        stalls = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk); #1;
                in_valid = 1'b0;
                in_set_flags = 1'b0;
                return;
            end
            stalls++;
            if (stalls > 3) out_ready = 1'b1;
            @(posedge clk); #1;
        end
        chk("accept_timeout", 32'(0), 32'(1));
        in_valid = 1'b0;
        in_set_flags = 1'b0;
    endtask

    task automatic send(input item_t it, input logic [3:0] op, input logic [3:0] nzcv,
                        input logic sf, output int stalls);
        drive(it, op, nzcv, sf);
        wait_accept(stalls);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int    st;
        int    e0;
        item_t a, b, c;

        // Reset
        cycles(4);
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_flags", 32'(flags_nzcv), 32'(0));
        chk("rst_carry", 32'(carry_out), 32'(0));
        chk("rst_out_result", 32'(out_result), 32'(0));
        chk("rst_out_rd", 32'(out_rd), 32'(0));
        chk("rst_in_ready", 32'(in_ready), 32'(0));
        rst = 1'b0;
        cycles(1);
        chk("post_rst_in_ready", 32'(in_ready), 32'(1));

        // ADD producing zero with carry
        out_ready = 1'b1;
        send(mk(16'h0000, 3'd1, 1'b1, 1'b0), 4'b0000, 4'b0110, 1'b1, st);
        chk("add_out_valid", 32'(out_valid), 32'(1));
        chk("add_out_result", 32'(out_result), 32'(16'h0000));
        chk("add_flags", 32'(flags_nzcv), 32'(4'b0110));
        chk("add_carry", 32'(carry_out), 32'(1));
        cycles(1);
        chk("add_drained", 32'(out_valid), 32'(0));

        // Back-pressure: A, B fill the buffer, C waits
        out_ready = 1'b0;
        a = mk(16'hAAAA, 3'd2, 1'b1, 1'b0);
        b = mk(16'hBBBB, 3'd3, 1'b0, 1'b1);
        c = mk(16'hCCCC, 3'd4, 1'b1, 1'b0);
        e0 = emits;
        send(a, 4'b0010, 4'b0000, 1'b0, st);
        chk("a_stalls", 32'(st), 32'(0));
        send(b, 4'b0010, 4'b0000, 1'b0, st);
        chk("b_stalls", 32'(st), 32'(0));
        chk("full_in_ready", 32'(in_ready), 32'(0));
        drive(c, 4'b0010, 4'b0000, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("held_in_ready", 32'(in_ready), 32'(0));
            chk("held_head", 32'(out_result), 32'(16'hAAAA));
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_accept(st);
        cycles(4);
        chk("abc_emitted", 32'(emits - e0), 32'(3));
        chk("abc_empty", 32'(out_valid), 32'(0));

        // Flag masking by op
        send(mk(16'h1, 3'd1, 1'b1, 1'b0), 4'b0000, 4'b0011, 1'b1, st);
        chk("flags_add", 32'(flags_nzcv), 32'(4'b0011));
        send(mk(16'h2, 3'd1, 1'b1, 1'b0), 4'b0010, 4'b1000, 1'b1, st);
        chk("flags_and", 32'(flags_nzcv), 32'(4'b1011));
        send(mk(16'h3, 3'd1, 1'b1, 1'b0), 4'b0101, 4'b0000, 1'b1, st);
        chk("flags_inc", 32'(flags_nzcv), 32'(4'b0011));
        chk("inc_keeps_v", 32'(flags_nzcv[0]), 32'(1));
        send(mk(16'h4, 3'd1, 1'b1, 1'b0), 4'b1101, 4'b1111, 1'b1, st);
        chk("flags_none", 32'(flags_nzcv), 32'(4'b0011));
        send(mk(16'h5, 3'd1, 1'b1, 1'b0), 4'b0110, 4'b1100, 1'b1, st);
        chk("flags_shl", 32'(flags_nzcv), 32'(4'b1101));
        send(mk(16'h6, 3'd1, 1'b1, 1'b0), 4'b0000, 4'b0000, 1'b0, st);
        chk("flags_no_set", 32'(flags_nzcv), 32'(4'b1101));

        // Random mix of ops, flags and downstream stalls
        for (int i = 0; i < 40; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            send(rnd_item(), 4'($urandom), 4'($urandom), 1'($urandom), st);
        end
        out_ready = 1'b1;
        cycles(3);

        // Flush in TWO with a flag-setting instruction on the input
        send(mk(16'h7, 3'd1, 1'b1, 1'b0), 4'b0000, 4'b1010, 1'b1, st);
        cycles(2);
        chk("pre_flush_flags", 32'(flags_nzcv), 32'(4'b1010));
        out_ready = 1'b0;
        send(mk(16'h8, 3'd2, 1'b1, 1'b0), 4'b0011, 4'b0000, 1'b0, st);
        send(mk(16'h9, 3'd3, 1'b1, 1'b0), 4'b0011, 4'b0000, 1'b0, st);
        drive(mk(16'hA, 3'd4, 1'b1, 1'b0), 4'b0000, 4'b0101, 1'b1);
        flush = 1'b1;
        cycles(1);
        flush = 1'b0; in_valid = 1'b0; in_set_flags = 1'b0;
        chk("flush2_out_valid", 32'(out_valid), 32'(0));
        chk("flush2_flags", 32'(flags_nzcv), 32'(4'b1010));
        chk("flush2_in_ready", 32'(in_ready), 32'(1));

        // Flush in ONE: the same-cycle accept must be dropped
        send(mk(16'hB, 3'd5, 1'b1, 1'b0), 4'b0011, 4'b0000, 1'b0, st);
        drive(mk(16'hC, 3'd6, 1'b1, 1'b0), 4'b0000, 4'b0101, 1'b1);
        flush = 1'b1;
        cycles(1);
        flush = 1'b0; in_valid = 1'b0; in_set_flags = 1'b0;
        chk("flush1_out_valid", 32'(out_valid), 32'(0));
        chk("flush1_flags", 32'(flags_nzcv), 32'(4'b1010));
        chk("flush1_in_ready", 32'(in_ready), 32'(1));
        cycles(1);
        chk("flush1_still_empty", 32'(out_valid), 32'(0));

        // Streaming: one item per cycle
        out_ready = 1'b1;
        e0 = emits;
        for (int i = 0; i < 100; i++) begin
            send(rnd_item(), 4'b0010, 4'b0000, 1'b0, st);
            chk("stream_stalls", 32'(st), 32'(0));
        end
        cycles(3);
        chk("stream_emitted", 32'(emits - e0), 32'(100));

`ifdef NEXUS_EXMEM_FWD_EN
        out_ready = 1'b0;
        send(mk(16'h1234, 3'd5, 1'b1, 1'b0), 4'b0000, 4'b0000, 1'b0, st);
        chk("fwd_alu_valid", 32'(fwd_valid), 32'(1));
        chk("fwd_alu_rd", 32'(fwd_rd), 32'(5));
        chk("fwd_alu_result", 32'(fwd_result), 32'(16'h1234));
        flush = 1'b1;
        cycles(1);
        flush = 1'b0;
        send(mk(16'h1234, 3'd5, 1'b1, 1'b1), 4'b0000, 4'b0000, 1'b0, st);
        chk("fwd_load_valid", 32'(fwd_valid), 32'(0));
        out_ready = 1'b1;
`endif

        out_ready = 1'b1;
        cycles(5);
        chk("final_queue_empty", 32'(q.size()), 32'(0));
        chk("final_out_valid", 32'(out_valid), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule

// File: doc/nexus_ex_mem_stage.md
NEXUS_EX_MEM_STAGE -- requirements
Module: nexus_ex_mem_stage

Interface
- REQ-001 SHALL have parameter RD_W, default 3: destination register index width.
- REQ-002 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
- REQ-003 SHALL have port rst  input  1: synchronous, active-high reset.
- REQ-004 SHALL have ports in_valid/in_ready  input/output  1/1: upstream (ALU side) handshake.
- REQ-005 SHALL have port in_alu_op  input  4: op that produced in_result.
- REQ-006 SHALL have port in_result  input  16: ALU result.
- REQ-007 SHALL have ports in_n/in_z/in_c/in_v  input  1 each: ALU flags.
- REQ-008 SHALL have port in_set_flags  input  1: instruction updates the flag register.
- REQ-009 SHALL have ports in_rd/in_wb_en  input  RD_W/1: destination index and writeback enable.
- REQ-010 SHALL have ports in_mem_rd/in_mem_wr/in_store_data  input  1/1/16: memory controls and store data.
- REQ-011 SHALL have port flush  input  1: discard all held and incoming entries.
- REQ-012 SHALL have ports out_valid/out_ready  output/input  1/1: downstream (MEM) handshake.
- REQ-013 SHALL have ports out_result, out_rd, out_wb_en, out_mem_rd, out_mem_wr, out_store_data  output  16/RD_W/1/1/1/16: head-entry payload.
- REQ-014 SHALL have port flags_nzcv  output  4: committed flags {N,Z,C,V}.
- REQ-015 SHALL have port carry_out  output  1: committed C, fed back to ALU carry_in.

Function
- REQ-016 SHALL be a two-entry in-order buffer (main + skid) with states EMPTY, ONE, TWO.
- REQ-017 in_ready SHALL be registered: 1 in EMPTY/ONE, 0 in TWO.
- REQ-018 Accept = in_valid && in_ready; emit = out_valid && out_ready; out_valid = 1 in ONE/TWO.
- REQ-019 Transitions: EMPTY+accept->ONE; ONE+accept-only->TWO; ONE+emit-only->EMPTY; ONE+accept+emit->ONE (new payload at head next cycle); TWO+emit->ONE (skid moves to head).
- REQ-020 Payload SHALL be registered unmodified; input-to-output latency 1 cycle when empty and out_ready=1.
- REQ-021 Out payload SHALL remain stable while out_valid && !out_ready.
- REQ-022 Flags SHALL commit at accept (not emit) when in_set_flags=1, visible next cycle.
- REQ-023 Flag mask by op: 0000/0001/1000 update NZCV; 1001/1100/0110 update NZC, keep V; 0010-0101, 0111, 1010, 1011 update NZ, keep CV; 1101-1111 update none.
- REQ-024 flush SHALL have priority: next state EMPTY, in_ready=1 next cycle, same-cycle accepted instruction discarded, its flags not committed; already committed flags unchanged.
- REQ-025 carry_out SHALL equal flags_nzcv[1] at all times.

Reset
- REQ-026 With rst=1 at an edge: state EMPTY, out_valid=0, flags_nzcv=4'b0000, carry_out=0; payload registers zero.
- REQ-027 in_ready SHALL be 0 during reset cycles and 1 on the first cycle after rst deasserts; rst overrides flush and any handshake.

Configuration
- REQ-028 Macro NEXUS_EXMEM_FWD_EN SHALL, when defined, add outputs fwd_valid (1), fwd_rd (RD_W), fwd_result (16) equal to head entry, fwd_valid = out_valid && out_wb_en && !out_mem_rd.
- REQ-029 Without NEXUS_EXMEM_FWD_EN these ports SHALL be absent and all other behaviour identical.

Structure
- REQ-030 Package nexus_pkg SHALL hold ALU op-code constants, flag bit indices (N=3,Z=2,C=1,V=0) and the buffer state enum.
- REQ-031 Flag masking and register SHALL be sub-module nexus_flag_reg; buffer control stays in the top.

Verification
- REQ-032 Reset then ADD result 16'h0000, C=1,Z=1, set_flags=1, out_ready=1 -> out_valid next cycle, out_result 0, flags_nzcv=4'b0110, carry_out=1.
- REQ-033 out_ready=0, three back-to-back valids (A,B,C) -> A,B accepted, in_ready=0 after second, C held; out_ready=1 -> A,B,C emitted in order, none lost/duplicated.
- REQ-034 flags 4'b0011, AND op with N=1,Z=0,C=0,V=0 -> flags 4'b1011; INC with V=0 then -> V kept 1.
- REQ-035 State TWO, flush=1 with in_valid=1, set_flags=1 -> out_valid=0 next cycle, flags unchanged, in_ready=1.
- REQ-036 ONE state, accept and emit same cycle continuously for 100 cycles -> 1 item/cycle throughput, in_ready never 0.
- REQ-037 With NEXUS_EXMEM_FWD_EN: head wb_en=1, mem_rd=0, rd=5, result 16'h1234 -> fwd_valid=1, fwd_rd=5, fwd_result 16'h1234; mem_rd=1 -> fwd_valid=0.
